// File: rtl/uart_rx_os.sv
// UART receive stage: a free-running 16x oversampling tick generator and a
// start/data/stop deserialiser that runs on the synchronised rx line.
module uart_rx_os #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR_W  = 11
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic              rx,
   output logic              s_tick,
   output logic              rx_done_tick,
   output logic [DBIT-1:0]   dout,
   output logic              frame_err,
   output logic [1:0]        fsm_state
);

   // The tick counter must reach SB_TICK-1, which needs 5 bits for 1.5 or 2 stop bits.
   localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
   localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] START = 2'b01;
   localparam logic [1:0] DATA  = 2'b10;
   localparam logic [1:0] STOP  = 2'b11;

   localparam logic [S_W-1:0]    S_ONE  = S_W'(1);
   localparam logic [S_W-1:0]    S_HALF = S_W'(7);
   localparam logic [S_W-1:0]    S_BIT  = S_W'(15);
   localparam logic [S_W-1:0]    S_STOP = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0]    N_ONE  = N_W'(1);
   localparam logic [N_W-1:0]    N_LAST = N_W'(DBIT - 1);
   localparam logic [DVSR_W-1:0] C_ONE  = DVSR_W'(1);

   logic              rx_meta;
   logic              rx_s;
   logic [DVSR_W-1:0] cnt;
   logic [1:0]        state;
   logic [S_W-1:0]    s;
   logic [N_W-1:0]    n;
   logic [DBIT-1:0]   b;

   assign fsm_state = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // >= rather than == so a smaller divisor written mid-count wraps at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         s_tick <= 1'b0;
      end else if (cnt >= dvsr) begin
         cnt    <= '0;
         s_tick <= 1'b1;
      end else begin
         cnt    <= cnt + C_ONE;
         s_tick <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  s     <= '0;
               end
            end
            START: begin
               // Half a bit in: a line that is high again was only a glitch.
               if (s_tick) begin
                  if (s == S_HALF) begin
                     if (!rx_s) begin
                        state <= DATA;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s <= s + S_ONE;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s == S_BIT) begin
                     b <= {rx_s, b[DBIT-1:1]};
                     s <= '0;
                     if (n == N_LAST) begin
                        state <= STOP;
                     end else begin
                        n <= n + N_ONE;
                     end
                  end else begin
                     s <= s + S_ONE;
                  end
               end
            end
            STOP: begin
               // The byte is delivered even when the stop bit is bad.
               if (s_tick) begin
                  if (s == S_STOP) begin
                     rx_done_tick <= 1'b1;
                     dout         <= b;
                     frame_err    <= ~rx_s;
                     state        <= IDLE;
                  end else begin
                     s <= s + S_ONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: serial frames are built from byte values and bit
// timings, and received bytes are scored against an expected queue.
module tb_uart_rx_os;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
   localparam int DVSR_W  = 11;
   localparam logic [1:0] IDLE_ST = 2'b00;

   logic              clk;
   logic              reset_n;
   logic [DVSR_W-1:0] dvsr;
   logic              rx;
   logic              s_tick;
   logic              rx_done_tick;
   logic [DBIT-1:0]   dout;
   logic              frame_err;
   logic [1:0]        fsm_state;

   int checks   = 0;
   int failures = 0;
   int stray_fe  = 0;
   int wide_done = 0;
   logic prev_done = 1'b0;

   // Entries are {frame_err, byte}.
   logic [DBIT:0] exp_q[$];
   logic [DBIT:0] obs_q[$];

   uart_rx_os #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR_W(DVSR_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .dvsr         (dvsr),
      .rx           (rx),
      .s_tick       (s_tick),
      .rx_done_tick (rx_done_tick),
      .dout         (dout),
      .frame_err    (frame_err),
      .fsm_state    (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (rx_done_tick) obs_q.push_back({frame_err, dout});
      if (frame_err && !rx_done_tick) stray_fe++;
      if (rx_done_tick && prev_done) wide_done++;
      prev_done = rx_done_tick;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic idle(input int clks);
      rx = 1'b1;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (16 * (int'(dvsr) + 1)) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DBIT-1:0] d, input logic stop_v);
      exp_q.push_back({~stop_v, d});
      send_bit(1'b0);
      for (int i = 0; i < DBIT; i++) send_bit(d[i]);
      send_bit(stop_v);
      rx = 1'b1;
   endtask

   task automatic apply_reset(input int clks);
      reset_n = 1'b0;
      repeat (clks) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic check_frames(input string name);
      int budget;
      logic [DBIT:0] e;
      logic [DBIT:0] o;
      int want;
      budget = 4000;
      want = exp_q.size();
      while (obs_q.size() < want && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checks++;
      if (obs_q.size() < want) begin
         failures++;
         $display("FAIL %s_count: got %0d frames, expected %0d", name, obs_q.size(), want);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL %s_frame: got dout=%h fe=%b, expected dout=%h fe=%b",
                     name, o[DBIT-1:0], o[DBIT], e[DBIT-1:0], e[DBIT]);
         end
      end
      exp_q.delete();
      repeat (40) @(negedge clk);
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL %s_extra: got %0d unexpected frames, expected 0", name, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_reset();
      int k;
      rx = 1'b1;
      dvsr = DVSR_W'(3);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (s_tick !== 1'b0) begin failures++; $display("FAIL reset_s_tick: got %b, expected 0", s_tick); end
      checks++;
      if (rx_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, expected 0", rx_done_tick); end
      checks++;
      if (dout !== '0) begin failures++; $display("FAIL reset_dout: got %h, expected 00", dout); end
      checks++;
      if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_fe: got %b, expected 0", frame_err); end
      checks++;
      if (fsm_state !== IDLE_ST) begin failures++; $display("FAIL reset_state: got %0d, expected %0d", fsm_state, IDLE_ST); end
      reset_n = 1'b1;
      // Counter starts at 0, so the first tick lands dvsr+1 clocks after release.
      k = 0;
      while (s_tick !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k != int'(dvsr) + 1) begin failures++; $display("FAIL reset_first_tick: got %0d clks, expected %0d", k, int'(dvsr) + 1); end
   endtask

   task automatic test_basic();
      idle(50);
      send_frame(8'hA5, 1'b1);
      check_frames("t1_a5");
   endtask

   task automatic test_glitch();
      idle(30);
      rx = 1'b0;
      repeat (20) @(negedge clk);
      idle(100);
      checks++;
      if (fsm_state !== IDLE_ST) begin failures++; $display("FAIL glitch_state: got %0d, expected %0d", fsm_state, IDLE_ST); end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL glitch_done: got %0d frames, expected 0", obs_q.size()); end
      send_frame(8'h3C, 1'b1);
      check_frames("t2_3c");
   endtask

   task automatic test_framing();
      idle(30);
      send_frame(8'h5A, 1'b0);
      check_frames("t3_5a");
      checks++;
      if (stray_fe != 0) begin failures++; $display("FAIL frame_err_alone: got %0d, expected 0", stray_fe); end
      // A stop bit held low can look like a fresh start edge; clear that out.
      apply_reset(5);
      idle(20);
   endtask

   task automatic test_back_to_back();
      idle(30);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h81, 1'b1);
      check_frames("t4_b2b");
      checks++;
      if (wide_done != 0) begin failures++; $display("FAIL done_width: got %0d wide pulses, expected 0", wide_done); end
      checks++;
      if (stray_fe != 0) begin failures++; $display("FAIL b2b_fe_alone: got %0d, expected 0", stray_fe); end
   endtask

   task automatic test_random();
      logic [DBIT-1:0] d;
      for (int i = 0; i < 6; i++) begin
         dvsr = DVSR_W'($urandom_range(0, 4));
         idle(40);
         d = DBIT'($urandom);
         send_frame(d, 1'b1);
         idle($urandom_range(0, 30));
      end
      check_frames("rand");
      dvsr = DVSR_W'(3);
   endtask

   task automatic test_reset_mid_frame();
      logic [DBIT-1:0] d;
      d = 8'hC3;
      idle(40);
      send_frame(8'h7E, 1'b1);
      check_frames("t5_pre");
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      rx = d[4];
      repeat (8 * (int'(dvsr) + 1)) @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (dout !== '0) begin failures++; $display("FAIL midreset_dout: got %h, expected 00", dout); end
      checks++;
      if (fsm_state !== IDLE_ST) begin failures++; $display("FAIL midreset_state: got %0d, expected %0d", fsm_state, IDLE_ST); end
      rx = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      idle(300);
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL midreset_done: got %0d frames, expected 0", obs_q.size()); end
      obs_q.delete();
      send_frame(d, 1'b1);
      check_frames("t5_c3");
   endtask

   task automatic test_fast_baud();
      int k;
      int lows;
      dvsr = '0;
      repeat (3) @(negedge clk);
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         if (s_tick !== 1'b1) lows++;
         @(negedge clk);
      end
      checks++;
      if (lows != 0) begin failures++; $display("FAIL tick_dvsr0: got %0d low cycles, expected 0", lows); end
      idle(20);
      send_frame(8'h96, 1'b1);
      check_frames("t6_96");
      dvsr = DVSR_W'(7);
      repeat (20) @(negedge clk);
      k = 0;
      while (s_tick !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      for (int p = 0; p < 3; p++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (s_tick !== 1'b1 && k < 50);
         checks++;
         if (k != 8) begin failures++; $display("FAIL tick_period_dvsr7: got %0d clks, expected 8", k); end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      rx = 1'b1;
      dvsr = DVSR_W'(3);
      @(negedge clk);
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      test_fast_baud();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
